// File: rtl/codec_sample_fifo_if.sv
// Generator/codec-facing bundle for the sample FIFO: push handshake, frame strobe, flush, and status.
// The master modport is the player/codec side and the slave modport is the FIFO.
interface codec_sample_fifo_if #(
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 4
);
  logic [WIDTH-1:0]  in_sample;
  logic              in_valid;
  logic              in_ready;
  logic              new_frame;
  logic              flush;
  logic [WIDTH-1:0]  sample_out;
  logic              streaming;
  logic [ADDR_W:0]   level;
  logic [15:0]       underrun_count;

  modport master (
    output in_sample, in_valid, new_frame, flush,
    input  in_ready, sample_out, streaming, level, underrun_count
  );

  modport slave (
    input  in_sample, in_valid, new_frame, flush,
    output in_ready, sample_out, streaming, level, underrun_count
  );
endinterface

// File: rtl/codec_sample_fifo.sv
// Elastic sample FIFO between generator and AC97 codec; one pop per new_frame once prefilled.
// Pops are registered (sample_out valid the cycle after new_frame); in_ready drops when full or flushing.
module codec_sample_fifo #(
  parameter int WIDTH   = 18,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int PREFILL = 8
) (
  input  logic               clk,
  input  logic               reset,
  codec_sample_fifo_if.slave bus
);
  typedef enum logic {S_FILL, S_STREAM} state_t;

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PREFILL_L = (ADDR_W+1)'(PREFILL);

  state_t             state_q;
  logic               streaming_q;
  logic [ADDR_W-1:0]  wr_q, wr_d;
  logic [ADDR_W-1:0]  rd_q, rd_d;
  logic [ADDR_W:0]    level_q, level_d;
  logic [WIDTH-1:0]   sample_q;
  logic [15:0]        urun_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic push, pop, underrun, frame_stream;

  assign bus.in_ready       = (level_q != DEPTH_L) && !bus.flush;
  assign bus.sample_out     = sample_q;
  assign bus.streaming      = streaming_q;
  assign bus.level          = level_q;
  assign bus.underrun_count = urun_q;

  always_comb begin
    push         = bus.in_valid && bus.in_ready;
    frame_stream = bus.new_frame && (state_q == S_STREAM) && !bus.flush;
    pop          = frame_stream && (level_q != '0);
    underrun     = frame_stream && (level_q == '0);
    wr_d         = push ? wr_q + 1'b1 : wr_q;
    rd_d         = pop  ? rd_q + 1'b1 : rd_q;
    level_d      = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    if (bus.flush) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end
  end

  // Storage needs no reset; only occupied entries are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= bus.in_sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FILL;
      streaming_q <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      sample_q    <= '0;
      urun_q      <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      if (bus.flush) begin
        state_q     <= S_FILL;
        streaming_q <= 1'b0;
        sample_q    <= '0;
      end else begin
        case (state_q)
          S_FILL: begin
            if (bus.new_frame) begin
              sample_q <= '0;
            end
            // Leaving FILL looks at the level before this edge's push lands.
            if (level_q >= PREFILL_L) begin
              state_q     <= S_STREAM;
              streaming_q <= 1'b1;
            end
          end
          S_STREAM: begin
            if (pop) begin
              sample_q <= mem_q[rd_q];
            end else if (underrun) begin
              sample_q    <= '0;
              state_q     <= S_FILL;
              streaming_q <= 1'b0;
              if (urun_q != 16'hFFFF) begin
                urun_q <= urun_q + 16'd1;
              end
            end
          end
          default: begin
            state_q     <= S_FILL;
            streaming_q <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_codec_sample_fifo.sv
// Directed bench for codec_sample_fifo with a queue-based reference model checked every cycle.
module tb_codec_sample_fifo;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  codec_sample_fifo_if #(.WIDTH(18), .ADDR_W(4)) bus ();

  codec_sample_fifo #(.WIDTH(18), .DEPTH(16), .ADDR_W(4), .PREFILL(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model: a queue of samples plus FILL/STREAM flag.
  logic [17:0] mq[$];
  bit          m_stream;
  logic [17:0] m_out;
  int          m_urun;
  int          m_lvl;
  bit          m_push;
  logic [17:0] m_in;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_stream = 1'b0;
      m_out    = '0;
      m_urun   = 0;
    end else if (bus.flush) begin
      mq.delete();
      m_stream = 1'b0;
      m_out    = '0;
    end else begin
      m_lvl  = mq.size();
      m_push = bus.in_valid && (m_lvl != 16);
      m_in   = bus.in_sample;
      if (!m_stream) begin
        if (bus.new_frame) m_out = '0;
        if (m_lvl >= 8) m_stream = 1'b1;
      end else if (bus.new_frame) begin
        if (m_lvl > 0) begin
          m_out = mq.pop_front();
        end else begin
          m_out    = '0;
          m_stream = 1'b0;
          if (m_urun < 65535) m_urun++;
        end
      end
      if (m_push) mq.push_back(m_in);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_level",     32'(bus.level),          32'(mq.size()));
    check("cyc_streaming", 32'(bus.streaming),      32'(m_stream));
    check("cyc_sample",    32'(bus.sample_out),     32'(m_out));
    check("cyc_underrun",  32'(bus.underrun_count), 32'(m_urun));
    check("cyc_in_ready",  32'(bus.in_ready),       32'((mq.size() != 16) && !bus.flush));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_sample = 18'(base + i);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic frame();
    bus.new_frame = 1'b1;
    step();
    bus.new_frame = 1'b0;
  endtask

  initial begin
    bus.in_sample = '0;
    bus.in_valid  = 1'b0;
    bus.new_frame = 1'b0;
    bus.flush     = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("reset_level",  32'(bus.level), 0);
    check("reset_stream", 32'(bus.streaming), 0);
    check("reset_sample", 32'(bus.sample_out), 0);

    // Prefill threshold
    push_n(1, 7);
    check("pre7_level",    32'(bus.level), 7);
    check("pre7_stream",   32'(bus.streaming), 0);
    check("pre7_in_ready", 32'(bus.in_ready), 1);
    push_n(8, 1);
    check("pre8_level",  32'(bus.level), 8);
    check("pre8_stream", 32'(bus.streaming), 0);
    step();
    check("pre8_stream_next", 32'(bus.streaming), 1);

    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush1_level", 32'(bus.level), 0);

    // Prefill 100..107 then three frames
    push_n(100, 8);
    step();
    check("p100_stream", 32'(bus.streaming), 1);
    for (int k = 0; k < 3; k++) begin
      frame();
      check("p100_sample", 32'(bus.sample_out), 32'(100 + k));
      step();
    end
    check("p100_level", 32'(bus.level), 5);

    // Fill to full, then hold off the 17th
    push_n(200, 11);
    check("full_level", 32'(bus.level), 16);
    bus.in_valid  = 1'b1;
    bus.in_sample = 18'd211;
    step();
    check("full_held_level", 32'(bus.level), 16);
    check("full_in_ready",   32'(bus.in_ready), 0);
    bus.new_frame = 1'b1;
    step();
    bus.new_frame = 1'b0;
    check("full_pop_level",  32'(bus.level), 15);
    check("full_pop_sample", 32'(bus.sample_out), 103);
    step();
    bus.in_valid = 1'b0;
    check("full_refill_level", 32'(bus.level), 16);

    // Drain all 16 in order, across pointer wrap
    for (int i = 0; i < 16; i++) begin
      frame();
      check("drain_sample", 32'(bus.sample_out), (i < 4) ? 32'(104 + i) : 32'(200 + i - 4));
      step();
    end
    frame();
    check("urun1_sample", 32'(bus.sample_out), 0);
    check("urun1_count",  32'(bus.underrun_count), 1);
    check("urun1_stream", 32'(bus.streaming), 0);

    push_n(300, 8);
    step();
    check("resume_stream", 32'(bus.streaming), 1);
    for (int k = 0; k < 3; k++) begin
      frame();
      check("resume_sample", 32'(bus.sample_out), 32'(300 + k));
      step();
    end
    for (int k = 0; k < 6; k++) begin
      frame();
      step();
    end
    check("urun2_count", 32'(bus.underrun_count), 2);

    // Flush with push and frame in the same cycle
    push_n(400, 10);
    step();
    frame();
    check("pflush_sample", 32'(bus.sample_out), 400);
    push_n(410, 1);
    check("pflush_level", 32'(bus.level), 10);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sample = 18'd999;
    bus.new_frame = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.new_frame = 1'b0;
    check("flush_level",  32'(bus.level), 0);
    check("flush_sample", 32'(bus.sample_out), 0);
    check("flush_stream", 32'(bus.streaming), 0);
    check("flush_urun",   32'(bus.underrun_count), 2);

    // Asynchronous reset between edges
    push_n(500, 12);
    check("prereset_level", 32'(bus.level), 12);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("areset_level",  32'(bus.level), 0);
    check("areset_stream", 32'(bus.streaming), 0);
    check("areset_urun",   32'(bus.underrun_count), 0);
    check("areset_sample", 32'(bus.sample_out), 0);
    step();
    reset = 1'b0;
    step();
    push_n(600, 8);
    step();
    check("post_stream", 32'(bus.streaming), 1);
    frame();
    check("post_sample", 32'(bus.sample_out), 600);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
